// File: rtl/flit_input_fifo.sv
// flit_input_fifo: NoC router input buffer with CTS handshake; define FLIT_FIFO_ERR_EN for sticky overflow/underflow flags.
module flit_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
`ifdef FLIT_FIFO_ERR_EN
  output logic                  err_overflow,
  output logic                  err_underflow,
`endif
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic any_rd, write_en, read_en;
  always_comb begin
    any_rd   = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    empty    = count == '0;
    full     = count == CW'(DEPTH);
    write_en = DRTS & ~CTS & ~full;
    read_en  = any_rd & ~empty;
    Data_out = mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (write_en && !rst) mem[wr_ptr] <= RX;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      CTS    <= 1'b0;
    end else begin
      CTS <= write_en;
      if (write_en) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (read_en) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= write_en && !read_en ? count + 1'b1 : !write_en && read_en ? count - 1'b1 : count;
    end
  end
`ifdef FLIT_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow | (DRTS & full & ~read_en);
      err_underflow <= err_underflow | (any_rd & empty);
    end
  end
`endif
endmodule

// File: tb/tb_flit_input_fifo.sv
// tb_flit_input_fifo: directed checks of handshake, ordering, wrap, full/empty and reset override.
module tb_flit_input_fifo;
  logic clk = 0, rst = 1, DRTS = 0;
  logic read_en_N = 0, read_en_E = 0, read_en_W = 0, read_en_S = 0, read_en_L = 0;
  logic [31:0] RX = '0, Data_out;
  logic CTS, empty, full;
  int checks = 0, errors = 0, pulses;
  logic prev_cts;
`ifdef FLIT_FIFO_ERR_EN
  logic err_overflow, err_underflow;
`endif
  always #5 clk = ~clk;
  flit_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .CTS(CTS),
`ifdef FLIT_FIFO_ERR_EN
    .err_overflow(err_overflow), .err_underflow(err_underflow),
`endif
    .Data_out(Data_out), .empty(empty), .full(full));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    #1;
    step();
    step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_cts", CTS, 0);
    rst = 0;
    DRTS = 1;
    RX = 32'hA5A5A5A5;
    step();
    chk("first_cts1", CTS, 1);
    chk("first_data", Data_out, 32'hA5A5A5A5);
    DRTS = 0;
    step();
    chk("first_cts0", CTS, 0);
    chk("first_empty", empty, 0);
    chk("first_data2", Data_out, 32'hA5A5A5A5);
    do_reset();
    DRTS = 1;
    RX = 1;
    pulses = 0;
    prev_cts = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (CTS) begin
        pulses++;
        RX = RX + 1;
      end
      if (prev_cts) chk("cts_back2back", CTS, 0);
      prev_cts = CTS;
    end
    chk("fill_pulses", pulses, 4);
    chk("fill_full", full, 1);
    step();
    chk("full_cts_low", CTS, 0);
    chk("full_head", Data_out, 1);
    chk("full_next_rx", RX, 5);
`ifdef FLIT_FIFO_ERR_EN
    chk("err_overflow", err_overflow, 1);
`endif
    read_en_E = 1;
    step();
    read_en_E = 0;
    chk("rd_adv_data", Data_out, 2);
    chk("rd_adv_notfull", full, 0);
    chk("rd_adv_cts", CTS, 0);
    step();
    chk("refill_cts", CTS, 1);
    chk("refill_full", full, 1);
    DRTS = 0;
    read_en_E = 1;
    for (int k = 2; k <= 5; k++) begin
      chk("wrap_order", Data_out, k);
      step();
    end
    read_en_E = 0;
    chk("wrap_drained", empty, 1);
    DRTS = 1;
    RX = 10;
    step();
    RX = 11;
    step();
    step();
    chk("cnt2_cts", CTS, 1);
    RX = 12;
    step();
    chk("cnt2_gap", CTS, 0);
    read_en_L = 1;
    step();
    DRTS = 0;
    chk("rw_cts", CTS, 1);
    chk("rw_data", Data_out, 11);
    chk("rw_empty", empty, 0);
    chk("rw_full", full, 0);
    step();
    chk("rw_order", Data_out, 12);
    chk("rw_one_left", empty, 0);
    step();
    read_en_L = 0;
    chk("rw_drained", empty, 1);
    read_en_N = 1;
    step();
    read_en_N = 0;
    chk("ufl_empty", empty, 1);
`ifdef FLIT_FIFO_ERR_EN
    chk("err_underflow", err_underflow, 1);
`endif
    DRTS = 1;
    RX = 32'h77;
    step();
    DRTS = 0;
    chk("ufl_ptr_data", Data_out, 32'h77);
    step();
`ifdef FLIT_FIFO_ERR_EN
    chk("err_underflow_sticky", err_underflow, 1);
`endif
    read_en_W = 1;
    step();
    read_en_W = 0;
    chk("ufl_drain", empty, 1);
    DRTS = 1;
    RX = 20;
    for (int i = 0; i < 5; i++) begin
      step();
      if (CTS) RX = RX + 1;
    end
    chk("cnt3_cts", CTS, 1);
    chk("cnt3_notfull", full, 0);
    rst = 1;
    read_en_S = 1;
    step();
    chk("rstov_empty", empty, 1);
    chk("rstov_cts", CTS, 0);
    chk("rstov_full", full, 0);
`ifdef FLIT_FIFO_ERR_EN
    chk("rst_err_clear", err_underflow | err_overflow, 0);
`endif
    rst = 0;
    DRTS = 0;
    read_en_S = 0;
    step();
    chk("rstov_stays_empty", empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flit_input_fifo.md
FLIT_INPUT_FIFO -- requirements
Module: flit_input_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: flit width in bits.
REQ-002 Parameter DEPTH, default 4: number of flit slots; the only legal values are 2, 4 or 8.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port RX, input, DATA_WIDTH: incoming flit from the upstream sender.
REQ-006 Port DRTS, input, 1: request-to-send from the upstream sender's RTS output.
REQ-007 Ports read_en_N, read_en_E, read_en_W, read_en_S, read_en_L, input, 1 each: grants from the downstream output arbiters.
REQ-008 Port CTS, output, 1: clear-to-send; a one-cycle pulse, registered, that goes to the upstream DCTS input.
REQ-009 Port Data_out, output, DATA_WIDTH: flit at the head of the FIFO.
REQ-010 Port empty, output, 1: FIFO holds no flits.
REQ-011 Port full, output, 1: FIFO holds DEPTH flits.

Function
REQ-012 The block SHALL assert write_en, an internal signal, when DRTS=1, CTS=0 and full=0.
REQ-013 The block SHALL drive the next value of CTS equal to write_en.
- CTS is a single-cycle pulse per flit.
- CTS is never high on two consecutive cycles.
REQ-014 On a clock edge with write_en=1, the block SHALL store RX at the write pointer and advance the write pointer by one slot.
- Latency: a flit is visible on Data_out on the cycle after the write edge, if the FIFO was empty.
REQ-015 The block SHALL form read_en as the OR of the five read_en_* inputs, gated by empty=0.
REQ-016 On a clock edge with read_en=1, the block SHALL advance the read pointer by one slot.
REQ-017 Data_out SHALL be a combinational function of the storage slot at the read pointer.
REQ-018 The block SHALL track occupancy as a count from 0 to DEPTH.
- Write only: count +1.
- Read only: count -1.
- Write and read in the same cycle: count unchanged, both pointers advance.
REQ-019 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 empty SHALL be high when count==0, and full SHALL be high when count==DEPTH; both are derived combinationally from registered state.
REQ-021 When full=1, DRTS SHALL be ignored and CTS SHALL stay at 0.
- A read in the same cycle frees a slot.
- CTS may pulse on the following cycle.
REQ-022 When empty=1, any read_en_* assertion SHALL be ignored: no pointer movement and no count change.
REQ-023 While DRTS is held high and the FIFO is not full, the block SHALL accept one flit every two cycles.

Reset
REQ-024 On a clock edge with rst=1, the block SHALL clear:
- the write pointer and read pointer;
- the count;
- CTS, to 0.
REQ-025 After reset, outputs SHALL be empty=1 and full=0.
- Data_out is undefined.
- Storage contents are not cleared.
REQ-026 When rst=1, it SHALL override any write or read in the same cycle.
- Flits in flight are discarded.
- A CTS pulse pending for that edge is cancelled.

Configuration
REQ-027 With macro FLIT_FIFO_ERR_EN defined, the block SHALL add two sticky output ports, err_overflow and err_underflow, each 1 bit.
- err_overflow sets when DRTS=1, full=1 and no read occurs in the same cycle.
- err_underflow sets when any read_en_* is high while empty=1.
- Both flags clear only on reset.
REQ-028 With FLIT_FIFO_ERR_EN undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then DRTS=1 with RX=0xA5A5A5A5 -> CTS=1 on cycle 1, CTS=0 on cycle 2, empty=0 and Data_out=0xA5A5A5A5 from cycle 2.
REQ-030 Hold DRTS=1 for 8 cycles, no reads, flits 1,2,3,4 -> 4 CTS pulses, then full=1 and CTS stays 0.
REQ-031 FIFO full, DRTS=1, pulse read_en_E once -> Data_out advances to flit 2 and count=3 next cycle; CTS pulses one cycle later and flit 5 is stored in the wrapped slot 0.
REQ-032 Count=2, write_en and read_en_L in the same cycle -> count stays 2, both pointers advance, and data order is preserved.
REQ-033 Empty FIFO, read_en_N=1 -> pointers are unchanged and empty stays 1; with FLIT_FIFO_ERR_EN, err_underflow=1 and stays 1 until rst.
REQ-034 Count=3, assert rst together with DRTS=1 and read_en_S=1 -> next cycle count=0, empty=1, CTS=0.
